// File: rtl/riscv_pkg.sv
// riscv_pkg
//   Shared definitions for the RV32I hazard controller.
//   - 5-bit major opcode constants (instruction bits [6:2])
//   - forwarding select encodings
//   - hazard shadow-tag struct carried alongside the EX and MEM stages
//   - tag_match(): does a tagged producer feed a given source register?
package riscv_pkg;

  localparam int REG_W = 5;

  localparam logic [4:0] R_TYPE     = 5'b01100;
  localparam logic [4:0] I_CAL      = 5'b00100;
  localparam logic [4:0] I_LOAD     = 5'b00000;
  localparam logic [4:0] S_TYPE     = 5'b01000;
  localparam logic [4:0] B_TYPE     = 5'b11000;
  localparam logic [4:0] LUI_TYPE   = 5'b01101;
  localparam logic [4:0] AUIPC_TYPE = 5'b00101;
  localparam logic [4:0] JAL_TYPE   = 5'b11011;
  localparam logic [4:0] JALR_TYPE  = 5'b11001;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // late = result only exists after MEM (loads and link writes of JAL/JALR)
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             we;
    logic             late;
  } hz_tag_t;

  localparam hz_tag_t TAG_INVALID = '0;

  // x0 is hard-wired, so a producer targeting it never forwards or stalls.
  function automatic logic tag_match(input hz_tag_t tag, input logic [REG_W-1:0] rs,
                                     input logic used);
    return tag.valid & tag.we & (tag.rd != '0) & (tag.rd == rs) & used;
  endfunction

endpackage

// File: rtl/hz_decode.sv
// hz_decode
//   Purely combinational classification of the instruction sitting in ID.
//   Ports:
//     inst_i     in  32  instruction word
//     we_o       out 1   instruction writes rd
//     late_o     out 1   result only available after MEM
//     uses_rs1_o out 1   rs1 is a real source operand
//     uses_rs2_o out 1   rs2 is a real source operand
//     rd_o       out 5   destination register field
//     rs1_o      out 5   source register 1 field
//     rs2_o      out 5   source register 2 field
module hz_decode
  import riscv_pkg::*;
(
  input  logic [31:0] inst_i,
  output logic        we_o,
  output logic        late_o,
  output logic        uses_rs1_o,
  output logic        uses_rs2_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o
);

  logic [4:0] opcode;
  logic       unused_bits;

  assign opcode = inst_i[6:2];
  assign rd_o   = inst_i[11:7];
  assign rs1_o  = inst_i[19:15];
  assign rs2_o  = inst_i[24:20];

  // funct fields and the fixed 2'b11 quadrant bits do not affect hazards
  assign unused_bits = ^{inst_i[31:25], inst_i[14:12], inst_i[1:0]};

  always_comb begin
    we_o       = 1'b0;
    late_o     = 1'b0;
    uses_rs1_o = 1'b0;
    uses_rs2_o = 1'b0;
    case (opcode)
      R_TYPE: begin
        we_o = 1'b1; uses_rs1_o = 1'b1; uses_rs2_o = 1'b1;
      end
      I_CAL: begin
        we_o = 1'b1; uses_rs1_o = 1'b1;
      end
      I_LOAD: begin
        we_o = 1'b1; late_o = 1'b1; uses_rs1_o = 1'b1;
      end
      S_TYPE, B_TYPE: begin
        uses_rs1_o = 1'b1; uses_rs2_o = 1'b1;
      end
      LUI_TYPE, AUIPC_TYPE: begin
        we_o = 1'b1;
      end
      JAL_TYPE: begin
        we_o = 1'b1; late_o = 1'b1;
      end
      JALR_TYPE: begin
        we_o = 1'b1; late_o = 1'b1; uses_rs1_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Hazard controller for a 5-stage RV32I pipeline. Tracks shadow tags for
//   the EX and MEM stages, detects load-use hazards, issues branch flushes,
//   freezes on memory wait, and registers the EX-stage forwarding selects.
//   Ports:
//     clk, rst_n       clock, asynchronous active-low reset
//     id_inst/id_valid instruction in ID and its valid flag
//     ex_branch_taken  EX redirects the PC
//     mem_ready        data memory done; low freezes everything
//     stall_if_id, bubble_ex, flush_if_id, freeze   pipeline control
//     fwd_a_sel, fwd_b_sel   registered EX operand selects
//     stall_cnt, flush_cnt   saturating event counters
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      id_inst,
  input  logic             id_valid,
  input  logic             ex_branch_taken,
  input  logic             mem_ready,
  output logic             stall_if_id,
  output logic             bubble_ex,
  output logic             flush_if_id,
  output logic             freeze,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic       dec_we, dec_late, dec_uses_rs1, dec_uses_rs2;
  logic [4:0] dec_rd, dec_rs1, dec_rs2;

  hz_decode u_decode (
    .inst_i     (id_inst),
    .we_o       (dec_we),
    .late_o     (dec_late),
    .uses_rs1_o (dec_uses_rs1),
    .uses_rs2_o (dec_uses_rs2),
    .rd_o       (dec_rd),
    .rs1_o      (dec_rs1),
    .rs2_o      (dec_rs2)
  );

  hz_tag_t          ex_tag_q, ex_tag_d;
  hz_tag_t          mem_tag_q, mem_tag_d;
  logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic load_use;

  assign ex_hit_a  = tag_match(ex_tag_q,  dec_rs1, dec_uses_rs1);
  assign ex_hit_b  = tag_match(ex_tag_q,  dec_rs2, dec_uses_rs2);
  assign mem_hit_a = tag_match(mem_tag_q, dec_rs1, dec_uses_rs1);
  assign mem_hit_b = tag_match(mem_tag_q, dec_rs2, dec_uses_rs2);

  // A taken branch kills the ID instruction, so it cannot also stall;
  // a frozen pipe does not stall either (freeze already holds everything).
  assign freeze      = ~mem_ready;
  assign flush_if_id = ex_branch_taken & mem_ready;
  assign load_use    = id_valid & mem_ready & ~ex_branch_taken & ex_tag_q.late
                       & (ex_hit_a | ex_hit_b);
  assign stall_if_id = load_use;
  assign bubble_ex   = load_use | flush_if_id;

  always_comb begin
    ex_tag_d  = ex_tag_q;
    mem_tag_d = mem_tag_q;
    fwd_a_d   = fwd_a_q;
    fwd_b_d   = fwd_b_q;
    if (mem_ready) begin
      mem_tag_d = ex_tag_q;
      if (bubble_ex) begin
        ex_tag_d = TAG_INVALID;
        fwd_a_d  = FWD_RF;
        fwd_b_d  = FWD_RF;
      end else begin
        ex_tag_d = '{valid: id_valid, rd: dec_rd, we: dec_we, late: dec_late};
        // EX holds the younger producer, so it takes precedence over MEM
        fwd_a_d  = ex_hit_a ? FWD_MEM : (mem_hit_a ? FWD_WB : FWD_RF);
        fwd_b_d  = ex_hit_b ? FWD_MEM : (mem_hit_b ? FWD_WB : FWD_RF);
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((load_use | freeze) && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_if_id && (flush_cnt_q != {CNT_W{1'b1}}))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_tag_q    <= TAG_INVALID;
      mem_tag_q   <= TAG_INVALID;
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_tag_q    <= ex_tag_d;
      mem_tag_q   <= mem_tag_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
